// File: rtl/image_pkg.sv
// Shared types and constants for the BaseRAM image path.
// FSM state encoding plus frame geometry used as default sizing.
package image_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        SETUP,
        WRITE,
        HOLD
    } state_t;

    localparam int IMG_W       = 800;
    localparam int IMG_H       = 600;
    localparam int IMG_WORDS   = IMG_W * IMG_H / 4;
    localparam int SRAM_ADDR_W = 20;

endpackage

// File: rtl/byte_word_packer.sv
// Packs a byte stream into 32-bit words, byte 0 in [7:0].
// full flags the push that completes a word; word_next holds that word.
module byte_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  in_data,
    output logic        full,
    output logic [31:0] word_next
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        word_next = word_q;
        unique case (idx_q)
            2'd0: word_next[7:0]   = in_data;
            2'd1: word_next[15:8]  = in_data;
            2'd2: word_next[23:16] = in_data;
            2'd3: word_next[31:24] = in_data;
            default: word_next = word_q;
        endcase
    end

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clr) begin
            idx_d = 2'd0;
        end else if (push) begin
            idx_d  = idx_q + 2'd1;
            word_d = word_next;
        end
    end

    assign full = push && (idx_q == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= 2'd0;
            word_q <= 32'h0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/sram_image_writer.sv
// BaseRAM frame writer: packs UART bytes into words and runs SRAM writes.
// Optional SRAM_IMAGE_WRITER_CHECKSUM_EN adds a 16-bit byte-sum output.
import image_pkg::*;

module sram_image_writer #(
    parameter int                ADDR_W      = SRAM_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                IMAGE_WORDS = IMG_WORDS,
    parameter int                WE_CYCLES   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_data_o,
    output logic              ram_data_oe,
    output logic [3:0]        ram_be_n,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
`ifdef SRAM_IMAGE_WRITER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam int CNT_W = $clog2(IMAGE_WORDS + 1);
    localparam int WC_W  = $clog2(WE_CYCLES + 1);

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              oe_q, oe_d;
    logic              ce_n_q, ce_n_d;
    logic              we_n_q, we_n_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;

    logic        push;
    logic        pk_clr;
    logic        pk_full;
    logic [31:0] pk_word;

    assign push   = in_valid && in_ready_q;
    assign pk_clr = start && (state_q == IDLE);

    byte_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (pk_clr),
        .push      (push),
        .in_data   (in_data),
        .full      (pk_full),
        .word_next (pk_word)
    );

    always_comb begin
        state_d    = state_q;
        in_ready_d = in_ready_q;
        busy_d     = busy_q;
        done_d     = done_q;
        addr_d     = addr_q;
        data_d     = data_q;
        oe_d       = oe_q;
        ce_n_d     = ce_n_q;
        we_n_d     = we_n_q;
        count_d    = count_q;
        wcnt_d     = wcnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d     = BASE_ADDR;
                    count_d    = '0;
                    done_d     = 1'b0;
                    busy_d     = 1'b1;
                    in_ready_d = 1'b1;
                    state_d    = COLLECT;
                end
            end
            COLLECT: begin
                if (pk_full) begin
                    in_ready_d = 1'b0;
                    data_d     = pk_word;
                    ce_n_d     = 1'b0;
                    oe_d       = 1'b1;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                we_n_d  = 1'b0;
                wcnt_d  = '0;
                state_d = WRITE;
            end
            WRITE: begin
                if (wcnt_q == WC_W'(WE_CYCLES - 1)) begin
                    we_n_d  = 1'b1;
                    state_d = HOLD;
                end else begin
                    wcnt_d = wcnt_q + WC_W'(1);
                end
            end
            HOLD: begin
                ce_n_d  = 1'b1;
                oe_d    = 1'b0;
                addr_d  = addr_q + ADDR_W'(1);
                count_d = count_q + CNT_W'(1);
                if (count_q + CNT_W'(1) == CNT_W'(IMAGE_WORDS)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    in_ready_d = 1'b1;
                    state_d    = COLLECT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= 32'h0;
            oe_q       <= 1'b0;
            ce_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            count_q    <= '0;
            wcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            oe_q       <= oe_d;
            ce_n_q     <= ce_n_d;
            we_n_q     <= we_n_d;
            count_q    <= count_d;
            wcnt_q     <= wcnt_d;
        end
    end

`ifdef SRAM_IMAGE_WRITER_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (pk_clr) begin
            sum_d = 16'h0;
        end else if (push) begin
            sum_d = sum_q + 16'(in_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= 16'h0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`endif

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign ram_addr    = addr_q;
    assign ram_data_o  = data_q;
    assign ram_data_oe = oe_q;
    assign ram_ce_n    = ce_n_q;
    assign ram_we_n    = we_n_q;
    // Writes always cover the full word; reads belong to the display path.
    assign ram_be_n    = 4'b0000;
    assign ram_oe_n    = 1'b1;

endmodule

// File: tb/tb_sram_image_writer.sv
// Scoreboard bench: two writer instances (base 0x10 and 0xFFFFF, 2 words).
// Stimulus queues expected SRAM writes; a monitor checks every write cycle.
module tb_sram_image_writer;

    localparam int WE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'h0;
    logic       in_valid = 1'b0;

    logic        ir   [2];
    logic        bsy  [2];
    logic        dn   [2];
    logic [19:0] addr [2];
    logic [31:0] data [2];
    logic        doe  [2];
    logic [3:0]  ben  [2];
    logic        ce_n [2];
    logic        oe_n [2];
    logic        we_n [2];
`ifdef SRAM_IMAGE_WRITER_CHECKSUM_EN
    logic [15:0] csum [2];
`endif

    int n_vec  = 0;
    int n_fail = 0;

    logic [51:0] expq0[$];
    logic [51:0] expq1[$];

    always #10 clk = ~clk;

    sram_image_writer #(
        .ADDR_W(20), .BASE_ADDR(20'h00010), .IMAGE_WORDS(2), .WE_CYCLES(WE)
    ) u0 (
        .clk(clk), .rst(rst), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(ir[0]),
        .busy(bsy[0]), .done(dn[0]),
        .ram_addr(addr[0]), .ram_data_o(data[0]), .ram_data_oe(doe[0]),
        .ram_be_n(ben[0]), .ram_ce_n(ce_n[0]), .ram_oe_n(oe_n[0]),
        .ram_we_n(we_n[0])
`ifdef SRAM_IMAGE_WRITER_CHECKSUM_EN
        , .checksum(csum[0])
`endif
    );

    sram_image_writer #(
        .ADDR_W(20), .BASE_ADDR(20'hFFFFF), .IMAGE_WORDS(2), .WE_CYCLES(WE)
    ) u1 (
        .clk(clk), .rst(rst), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(ir[1]),
        .busy(bsy[1]), .done(dn[1]),
        .ram_addr(addr[1]), .ram_data_o(data[1]), .ram_data_oe(doe[1]),
        .ram_be_n(ben[1]), .ram_ce_n(ce_n[1]), .ram_oe_n(oe_n[1]),
        .ram_we_n(we_n[1])
`ifdef SRAM_IMAGE_WRITER_CHECKSUM_EN
        , .checksum(csum[1])
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Write-cycle monitor: waveform shape plus scoreboard pop on HOLD.
    initial begin : monitor
        logic        prev_we [2];
        logic        prev_ce [2];
        logic        prev_oe [2];
        logic [19:0] prev_a  [2];
        logic [31:0] prev_d  [2];
        logic        posth   [2];
        int          wcnt    [2];
        logic [19:0] wa      [2];
        logic [31:0] wd      [2];
        logic [51:0] e;
        for (int i = 0; i < 2; i++) begin
            prev_we[i] = 1'b1; posth[i] = 1'b0; wcnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    prev_we[i] = 1'b1;
                    posth[i]   = 1'b0;
                    wcnt[i]    = 0;
                end else begin
                    if (i == 1) chk("ir_match", 64'(ir[1]), 64'(ir[0]));
                    if (posth[i]) begin
                        chk("post_hold_ce_n", 64'(ce_n[i]), 64'd1);
                        chk("post_hold_oe", 64'(doe[i]), 64'd0);
                        posth[i] = 1'b0;
                    end
                    if (!we_n[i]) begin
                        chk("wr_in_ready", 64'(ir[i]), 64'd0);
                        chk("wr_ce_n", 64'(ce_n[i]), 64'd0);
                        if (prev_we[i]) begin
                            chk("setup_ce_n", 64'(prev_ce[i]), 64'd0);
                            chk("setup_oe", 64'(prev_oe[i]), 64'd1);
                            chk("setup_addr", 64'(addr[i]), 64'(prev_a[i]));
                            chk("setup_data", 64'(data[i]), 64'(prev_d[i]));
                            wcnt[i] = 1;
                            wa[i] = addr[i];
                            wd[i] = data[i];
                        end else begin
                            wcnt[i]++;
                            chk("wr_addr_stable", 64'(addr[i]), 64'(wa[i]));
                            chk("wr_data_stable", 64'(data[i]), 64'(wd[i]));
                        end
                    end else if (!prev_we[i]) begin
                        chk("hold_ce_n", 64'(ce_n[i]), 64'd0);
                        chk("hold_oe", 64'(doe[i]), 64'd1);
                        chk("hold_data", 64'(data[i]), 64'(wd[i]));
                        chk("we_low_cycles", 64'(wcnt[i]), 64'(WE));
                        posth[i] = 1'b1;
                        if (i == 0 && expq0.size() > 0) begin
                            e = expq0.pop_front();
                            chk("write0_addr_data", 64'({wa[i], wd[i]}), 64'(e));
                        end else if (i == 1 && expq1.size() > 0) begin
                            e = expq1.pop_front();
                            chk("write1_addr_data", 64'({wa[i], wd[i]}), 64'(e));
                        end else begin
                            chk("unexpected_write", 64'({wa[i], wd[i]}), 64'h0);
                        end
                    end
                    prev_we[i] = we_n[i];
                end
                prev_ce[i] = ce_n[i];
                prev_oe[i] = doe[i];
                prev_a[i]  = addr[i];
                prev_d[i]  = data[i];
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (ir[0]) ok = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) chk("in_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (!bsy[0]) ok = 1'b1;
        end
        if (!ok) chk("busy_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_frame(input logic [63:0] bytes, input int gap,
                             input bit mid);
        logic [31:0] w;
        logic [19:0] a0, a1;
        logic [15:0] sum = 16'h0;
        for (int k = 0; k < 2; k++) begin
            w  = bytes[32*k +: 32];
            a0 = 20'h00010 + 20'(k);
            a1 = 20'hFFFFF + 20'(k);
            expq0.push_back({a0, w});
            expq1.push_back({a1, w});
        end
        for (int k = 0; k < 8; k++) sum = sum + 16'(bytes[8*k +: 8]);
        pulse_start();
        chk("busy_after_start", 64'(bsy[0]), 64'd1);
        chk("done_cleared", 64'(dn[0]), 64'd0);
        for (int k = 0; k < 8; k++) begin
            send_byte(bytes[8*k +: 8]);
            if (mid && k == 1) pulse_start();
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
        wait_idle();
        chk("done0", 64'(dn[0]), 64'd1);
        chk("done1", 64'(dn[1]), 64'd1);
        chk("idle_in_ready", 64'(ir[0]), 64'd0);
        chk("scoreboard0_drained", 64'(expq0.size()), 64'd0);
        chk("scoreboard1_drained", 64'(expq1.size()), 64'd0);
`ifdef SRAM_IMAGE_WRITER_CHECKSUM_EN
        chk("checksum0", 64'(csum[0]), 64'(sum));
        chk("checksum1", 64'(csum[1]), 64'(sum));
`endif
        repeat (4) @(posedge clk);
        #1;
        chk("done_sticky", 64'(dn[0]), 64'd1);
    endtask

    task automatic abort_in_write();
        bit ok = 1'b0;
        pulse_start();
        for (int k = 0; k < 4; k++) send_byte(8'hA0 + 8'(k));
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (!we_n[0]) ok = 1'b1;
        end
        if (!ok) chk("we_timeout", 64'd1, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_we_n", 64'(we_n[0]), 64'd1);
        chk("abort_ce_n", 64'(ce_n[0]), 64'd1);
        chk("abort_oe", 64'(doe[0]), 64'd0);
        chk("abort_busy", 64'(bsy[0]), 64'd0);
        chk("abort_in_ready", 64'(ir[0]), 64'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_ce_n", 64'(ce_n[i]), 64'd1);
            chk("rst_we_n", 64'(we_n[i]), 64'd1);
            chk("rst_oe_n", 64'(oe_n[i]), 64'd1);
            chk("rst_be_n", 64'(ben[i]), 64'd0);
            chk("rst_in_ready", 64'(ir[i]), 64'd0);
            chk("rst_data_oe", 64'(doe[i]), 64'd0);
            chk("rst_busy", 64'(bsy[i]), 64'd0);
            chk("rst_done", 64'(dn[i]), 64'd0);
            chk("rst_addr", 64'(addr[i]), 64'd0);
            chk("rst_data", 64'(data[i]), 64'd0);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_ce_n", 64'(ce_n[0]), 64'd1);
        chk("idle_in_ready", 64'(ir[0]), 64'd0);

        run_frame(64'h8877665544332211, 0, 1'b0);
        run_frame(64'h8877665544332211, 3, 1'b0);
        run_frame(64'h8877665544332211, 1, 1'b1);
        abort_in_write();
        run_frame(64'h0807060504030201, 0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            run_frame({$urandom, $urandom}, int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
